// File: rtl/poly_audiogen_pkg.sv
// Shared types and constants for the polyphonic tone generator: key tuning
// words, the detune offset, the envelope state encoding and waveform codes.
package poly_audiogen_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ATTACK  = 2'd1,
      SUSTAIN = 2'd2,
      RELEASE = 2'd3
   } env_state_t;

   typedef enum logic [1:0] {
      WAVE_SAW_UP   = 2'd0,
      WAVE_SQUARE   = 2'd1,
      WAVE_TRIANGLE = 2'd2,
      WAVE_SAW_DOWN = 2'd3
   } wave_sel_t;

   localparam logic [31:0] DETUNE_FTW = 32'd65536;

   function automatic logic [31:0] ftw_of(input int k);
      case (k)
         0:       return 32'd107786375;
         1:       return 32'd101736857;
         2:       return 32'd90637199;
         3:       return 32'd80749505;
         4:       return 32'd71891779;
         5:       return 32'd67874903;
         6:       return 32'd60459132;
         7:       return 32'd53867335;
         default: return 32'd0;
      endcase
   endfunction

endpackage

// File: rtl/poly_audiogen_voice.sv
// One voice: envelope FSM, NCO, waveform shaper and envelope multiply.
// DETUNE_EN adds a second NCO offset by DETUNE_FTW that shares the envelope.
//
// state   | meaning
// IDLE    | silent, phase frozen, env 0
// ATTACK  | env ramps up by attack_rate per strobe until full scale
// SUSTAIN | env held at full scale while the key is down
// RELEASE | env ramps down by release_rate per strobe until 0
module poly_voice
   import poly_audiogen_pkg::*;
#(
   parameter int                 PHASE_W = 32,
   parameter int                 WAVE_W  = 16,
   parameter int                 ENV_W   = 16,
   parameter logic [PHASE_W-1:0] FTW     = '0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     ena,
   input  logic                     i_key_on,
   input  logic [1:0]               i_wave_sel,
   input  logic [ENV_W-1:0]         i_attack_rate,
   input  logic [ENV_W-1:0]         i_release_rate,
   output logic                     o_act,
`ifdef DETUNE_EN
   output logic signed [WAVE_W-1:0] o_smp_r,
`endif
   output logic signed [WAVE_W-1:0] o_smp_l
);

   localparam int                PROD_W   = WAVE_W + ENV_W + 1;
   localparam logic [ENV_W-1:0]  ENV_MAX  = '1;
   localparam logic [WAVE_W-1:0] MSB_MASK = {1'b1, {(WAVE_W-1){1'b0}}};
   localparam logic [WAVE_W-1:0] SQ_HI    = {1'b0, {(WAVE_W-1){1'b1}}};
   localparam logic [WAVE_W-1:0] SQ_LO    = {1'b1, {(WAVE_W-2){1'b0}}, 1'b1};

   env_state_t                r_state, w_state_nxt;
   logic [ENV_W-1:0]          r_env, w_env_nxt, r_env_q;
   logic [PHASE_W-1:0]        r_phase;
   logic signed [WAVE_W-1:0]  r_wave, r_prod;
   logic [ENV_W:0]            w_env_sum;
   logic [ENV_W-1:0]          w_env_up, w_env_dn;
   logic                      w_clr_phase;
   logic signed [PROD_W-1:0]  w_prod;

   function automatic logic [WAVE_W-1:0] wave_of(input logic [WAVE_W-1:0] p,
                                                 input logic [1:0] sel);
      logic [WAVE_W-2:0] fold;
      fold = p[WAVE_W-1] ? ~p[WAVE_W-2:0] : p[WAVE_W-2:0];
      case (wave_sel_t'(sel))
         WAVE_SAW_UP:   return p ^ MSB_MASK;
         WAVE_SQUARE:   return p[WAVE_W-1] ? SQ_LO : SQ_HI;
         WAVE_TRIANGLE: return {fold, 1'b0} ^ MSB_MASK;
         default:       return ~(p ^ MSB_MASK);
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= IDLE;
         r_env   <= '0;
      end else if (ena) begin
         r_state <= w_state_nxt;
         r_env   <= w_env_nxt;
      end
   end

   assign w_env_sum = {1'b0, r_env} + {1'b0, i_attack_rate};
   assign w_env_up  = w_env_sum[ENV_W] ? ENV_MAX : w_env_sum[ENV_W-1:0];
   assign w_env_dn  = (r_env > i_release_rate) ? (r_env - i_release_rate) : '0;

   always_comb begin
      w_state_nxt = r_state;
      w_env_nxt   = r_env;
      case (r_state)
         IDLE:    if (i_key_on) w_state_nxt = ATTACK;
         ATTACK: begin
            if (!i_key_on) begin
               w_state_nxt = RELEASE;
            end else if (i_attack_rate != '0) begin
               w_env_nxt = w_env_up;
               if (w_env_up == ENV_MAX) w_state_nxt = SUSTAIN;
            end
         end
         SUSTAIN: if (!i_key_on) w_state_nxt = RELEASE;
         RELEASE: begin
            if (i_key_on) begin
               w_state_nxt = ATTACK;
            end else if (i_release_rate != '0) begin
               w_env_nxt = w_env_dn;
               if (w_env_dn == '0) w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_act       = (r_state != IDLE);
      w_clr_phase = (r_state == IDLE) && i_key_on;
   end

   // Envelope is unsigned, so widen it with a zero MSB before the signed multiply
   assign w_prod = PROD_W'(r_wave) * PROD_W'($signed({1'b0, r_env_q}));

`ifdef DETUNE_EN
   localparam logic [PHASE_W-1:0] FTW_D = FTW + PHASE_W'(DETUNE_FTW);
   logic [PHASE_W-1:0]       r_phase_d;
   logic signed [WAVE_W-1:0] r_wave_d, r_prod_d;
   logic signed [PROD_W-1:0] w_prod_d;

   assign w_prod_d = PROD_W'(r_wave_d) * PROD_W'($signed({1'b0, r_env_q}));
   assign o_smp_r  = r_prod_d;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_phase   <= '0;
         r_wave    <= '0;
         r_env_q   <= '0;
         r_prod    <= '0;
`ifdef DETUNE_EN
         r_phase_d <= '0;
         r_wave_d  <= '0;
         r_prod_d  <= '0;
`endif
      end else if (ena) begin
         if (w_clr_phase)  r_phase <= '0;
         else if (o_act)   r_phase <= r_phase + FTW;
         r_wave  <= wave_of(r_phase[PHASE_W-1 -: WAVE_W], i_wave_sel);
         r_env_q <= r_env;
         r_prod  <= WAVE_W'(w_prod >>> ENV_W);
`ifdef DETUNE_EN
         if (w_clr_phase)  r_phase_d <= '0;
         else if (o_act)   r_phase_d <= r_phase_d + FTW_D;
         r_wave_d <= wave_of(r_phase_d[PHASE_W-1 -: WAVE_W], i_wave_sel);
         r_prod_d <= WAVE_W'(w_prod_d >>> ENV_W);
`endif
      end
   end

   assign o_smp_l = r_prod;

endmodule

// File: rtl/poly_audiogen.sv
// Polyphonic tone generator top: key gating, NUM_KEYS voices and the stereo mixer.
// DETUNE_EN builds detuned chorus voices for r_data; otherwise r_data mirrors l_data.
module poly_audiogen
   import poly_audiogen_pkg::*;
#(
   parameter int NUM_KEYS = 8,
   parameter int PHASE_W  = 32,
   parameter int WAVE_W   = 16,
   parameter int ENV_W    = 16,
   parameter int DATA_W   = 24
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     ena,
   input  logic                     play,
   input  logic                     CS,
   input  logic [NUM_KEYS-1:0]      sw_tones,
   input  logic [1:0]               wave_sel,
   input  logic [ENV_W-1:0]         attack_rate,
   input  logic [ENV_W-1:0]         release_rate,
   output logic signed [DATA_W-1:0] l_data,
   output logic signed [DATA_W-1:0] r_data,
   output logic [NUM_KEYS-1:0]      voice_act
);

   localparam int MIX_W = WAVE_W + $clog2(NUM_KEYS);
   localparam int SHIFT = DATA_W - MIX_W;

   logic [NUM_KEYS-1:0]      w_key_on;
   logic signed [WAVE_W-1:0] w_smp_l [NUM_KEYS];
   logic signed [MIX_W-1:0]  w_mix_l;
   logic signed [DATA_W-1:0] r_l_data;

   assign w_key_on = sw_tones & {NUM_KEYS{play & CS}};

`ifdef DETUNE_EN
   logic signed [WAVE_W-1:0] w_smp_r [NUM_KEYS];
   logic signed [MIX_W-1:0]  w_mix_r;
   logic signed [DATA_W-1:0] r_r_data;
`endif

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_voice
      poly_voice #(
         .PHASE_W (PHASE_W),
         .WAVE_W  (WAVE_W),
         .ENV_W   (ENV_W),
         .FTW     (PHASE_W'(ftw_of(k)))
      ) u_voice (
         .clk            (clk),
         .reset          (reset),
         .ena            (ena),
         .i_key_on       (w_key_on[k]),
         .i_wave_sel     (wave_sel),
         .i_attack_rate  (attack_rate),
         .i_release_rate (release_rate),
         .o_act          (voice_act[k]),
`ifdef DETUNE_EN
         .o_smp_r        (w_smp_r[k]),
`endif
         .o_smp_l        (w_smp_l[k])
      );
   end

   // MIX_W has exactly enough headroom for NUM_KEYS full-scale voices
   always_comb begin
      w_mix_l = '0;
      for (int k = 0; k < NUM_KEYS; k++) w_mix_l = w_mix_l + MIX_W'(w_smp_l[k]);
   end

`ifdef DETUNE_EN
   always_comb begin
      w_mix_r = '0;
      for (int k = 0; k < NUM_KEYS; k++) w_mix_r = w_mix_r + MIX_W'(w_smp_r[k]);
   end
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_l_data <= '0;
`ifdef DETUNE_EN
         r_r_data <= '0;
`endif
      end else if (ena) begin
         r_l_data <= DATA_W'(w_mix_l) <<< SHIFT;
`ifdef DETUNE_EN
         r_r_data <= DATA_W'(w_mix_r) <<< SHIFT;
`endif
      end
   end

   assign l_data = r_l_data;
`ifdef DETUNE_EN
   assign r_data = r_r_data;
`else
   assign r_data = r_l_data;
`endif

endmodule

// File: tb/tb_poly_audiogen.sv
// Self-checking bench for poly_audiogen: directed scenarios plus random key
// traffic compared against an arithmetic model of the voices and mixer.
module tb_poly_audiogen;

   logic               clk = 1'b0;
   logic               reset, ena, play, CS;
   logic [7:0]         sw_tones;
   logic [1:0]         wave_sel;
   logic [15:0]        attack_rate, release_rate;
   logic signed [23:0] l_data, r_data;
   logic [7:0]         voice_act;

   int n_chk  = 0;
   int n_pass = 0;

   localparam int M_IDLE = 0, M_ATK = 1, M_SUS = 2, M_REL = 3;
   int unsigned tb_ftw [8] = '{107786375, 101736857, 90637199, 80749505,
                               71891779, 67874903, 60459132, 53867335};

   int          m_st  [8];
   longint      m_env [8];
   logic [31:0] m_ph  [8];
   logic [31:0] m_phd [8];
   longint      q_l [$];
   longint      q_r [$];
   logic [23:0] exp_l, exp_r;
   logic [7:0]  exp_act;

   poly_audiogen dut (
      .clk          (clk),
      .reset        (reset),
      .ena          (ena),
      .play         (play),
      .CS           (CS),
      .sw_tones     (sw_tones),
      .wave_sel     (wave_sel),
      .attack_rate  (attack_rate),
      .release_rate (release_rate),
      .l_data       (l_data),
      .r_data       (r_data),
      .voice_act    (voice_act)
   );

   always #5 clk = ~clk;

   function automatic longint wave_val(input logic [31:0] ph, input int sel);
      int u;
      u = int'(ph[31:16]);
      case (sel)
         0:       return longint'(u - 32768);
         1:       return (u >= 32768) ? -32767 : 32767;
         2:       return (u < 32768) ? longint'(2*u - 32768) : longint'(2*(65535-u) - 32768);
         default: return longint'(32767 - u);
      endcase
   endfunction

   function automatic longint mix_of(input bit det, input int sel);
      longint s;
      s = 0;
      for (int k = 0; k < 8; k++)
         s += (wave_val(det ? m_phd[k] : m_ph[k], sel) * m_env[k]) >>> 16;
      return s;
   endfunction

   task automatic model_update_exp();
      exp_l = 24'(q_l[0] * 32);
      exp_r = 24'(q_r[0] * 32);
      exp_act = '0;
      for (int k = 0; k < 8; k++) exp_act[k] = (m_st[k] != M_IDLE);
   endtask

   task automatic model_reset();
      for (int k = 0; k < 8; k++) begin
         m_st[k] = M_IDLE; m_env[k] = 0; m_ph[k] = '0; m_phd[k] = '0;
      end
      q_l = '{0, 0, 0};
      q_r = '{0, 0, 0};
      model_update_exp();
   endtask

   task automatic model_ena();
      longint xl, xr;
      logic [7:0] on;
      xl = mix_of(1'b0, int'(wave_sel));
`ifdef DETUNE_EN
      xr = mix_of(1'b1, int'(wave_sel));
`else
      xr = xl;
`endif
      q_l.push_back(xl); void'(q_l.pop_front());
      q_r.push_back(xr); void'(q_r.pop_front());
      on = sw_tones & {8{play & CS}};
      for (int k = 0; k < 8; k++) begin
         if (m_st[k] == M_IDLE) begin
            if (on[k]) begin
               m_ph[k] = '0; m_phd[k] = '0; m_st[k] = M_ATK;
            end
         end else begin
            m_ph[k]  = m_ph[k] + tb_ftw[k];
            m_phd[k] = m_phd[k] + tb_ftw[k] + 32'd65536;
            case (m_st[k])
               M_ATK: if (!on[k]) m_st[k] = M_REL;
                      else if (attack_rate != 0) begin
                         m_env[k] += attack_rate;
                         if (m_env[k] >= 65535) begin m_env[k] = 65535; m_st[k] = M_SUS; end
                      end
               M_SUS: if (!on[k]) m_st[k] = M_REL;
               default: if (on[k]) m_st[k] = M_ATK;
                      else if (release_rate != 0) begin
                         m_env[k] -= release_rate;
                         if (m_env[k] <= 0) begin m_env[k] = 0; m_st[k] = M_IDLE; end
                      end
            endcase
         end
      end
      model_update_exp();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".l_data"},    {8'h0, l_data},     {8'h0, exp_l});
      chk({tag, ".r_data"},    {8'h0, r_data},     {8'h0, exp_r});
      chk({tag, ".voice_act"}, {24'h0, voice_act}, {24'h0, exp_act});
   endtask

   task automatic do_ena(input string tag);
      @(negedge clk); ena = 1'b1;
      @(negedge clk); ena = 1'b0;
      model_ena();
      check_all(tag);
   endtask

   initial begin
      reset = 1'b0; ena = 1'b0; play = 1'b0; CS = 1'b0; sw_tones = '0;
      wave_sel = 2'd0; attack_rate = '0; release_rate = '0;

      // reset held for 4 clocks while ena toggles
      repeat (4) @(negedge clk) ena = ~ena;
      @(negedge clk); ena = 1'b0; reset = 1'b1;
      model_reset();
      check_all("reset");

      // single key, instant attack, square wave
      sw_tones = 8'h01; play = 1'b1; CS = 1'b1; attack_rate = 16'hFFFF; wave_sel = 2'd1;
      do_ena("t2_e1");
      chk("t2_act_first", {24'h0, voice_act}, 32'h1);
      repeat (4) do_ena("t2");
      chk("t2_full_square", {8'h0, l_data}, 32'h000FFFC0);

      // release after CS drop: four decrement steps to silence
      CS = 1'b0; release_rate = 16'h4000;
      repeat (4) do_ena("t3");
      chk("t3_still_act", {24'h0, voice_act}, 32'h1);
      do_ena("t3_last");
      chk("t3_idle", {24'h0, voice_act}, 32'h0);
      repeat (3) do_ena("t3_flush");

      // all keys at full scale: largest positive mix
      CS = 1'b1; sw_tones = 8'hFF; attack_rate = 16'hFFFF; wave_sel = 2'd1;
      repeat (5) do_ena("t4");
      chk("t4_all_keys", {8'h0, l_data}, 32'h007FFE00);

      // random key traffic with idle gaps between strobes
      for (int i = 0; i < 200; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         if ($urandom_range(0, 3) == 0) sw_tones = 8'($urandom);
         play = ($urandom_range(0, 9) != 0);
         CS   = ($urandom_range(0, 9) != 0);
         wave_sel = 2'($urandom);
         case ($urandom_range(0, 3))
            0: attack_rate = '0;
            1: attack_rate = 16'($urandom_range(1, 255));
            2: attack_rate = 16'($urandom);
            default: attack_rate = 16'hFFFF;
         endcase
         case ($urandom_range(0, 3))
            0: release_rate = '0;
            1: release_rate = 16'($urandom_range(1, 255));
            2: release_rate = 16'($urandom);
            default: release_rate = 16'hFFFF;
         endcase
         do_ena("rand");
      end

      // long ena-low stretch mid-note
      sw_tones = 8'hA5; play = 1'b1; CS = 1'b1; attack_rate = 16'h1234; wave_sel = 2'd2;
      repeat (3) do_ena("hold_pre");
      sw_tones = 8'h5A; attack_rate = 16'hFFFF;
      repeat (100) @(negedge clk);
      check_all("hold");

      // reset during attack, with ena also high
      sw_tones = 8'hFF; attack_rate = 16'h0100;
      repeat (3) do_ena("rst_pre");
      @(negedge clk); reset = 1'b0; ena = 1'b1;
      @(negedge clk); reset = 1'b1; ena = 1'b0;
      model_reset();
      check_all("rst_mid");

      // zero attack rate stalls in ATTACK with silent output
      sw_tones = 8'h04; attack_rate = '0; wave_sel = 2'd1;
      repeat (6) do_ena("t6");
      chk("t6_act", {24'h0, voice_act}, 32'h4);
      chk("t6_silent", {8'h0, l_data}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
